// File: rtl/udma_filter_sched.sv
// Round-robin scheduler sharing one uDMA filter: programs a granted requester's
// descriptor over the filter cfg bus, starts it, and reports done/timeout per requester.
module udma_filter_sched #(
    parameter int         NREQ        = 4,
    parameter int         NUM_WORDS   = 4,
    parameter logic [4:0] BASE_ADDR   = 5'h00,
    parameter logic [4:0] START_ADDR  = 5'h14,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic                          sys_clk_i,
    input  logic                          rstn_i,
    input  logic [NREQ-1:0]               req_i,
    input  logic [NREQ*NUM_WORDS*32-1:0]  job_data_i,
    output logic [NREQ-1:0]               gnt_o,
    output logic [NREQ-1:0]               done_o,
    output logic [NREQ-1:0]               err_o,
    output logic                          busy_o,
    output logic [31:0]                   cfg_data_o,
    output logic [4:0]                    cfg_addr_o,
    output logic                          cfg_valid_o,
    output logic                          cfg_rwn_o,
    input  logic                          cfg_ready_i,
    input  logic                          eot_event_i
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WRITE, S_START, S_WAIT} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       desc_q [NUM_WORDS];
    logic [31:0]       desc_d [NUM_WORDS];
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic              busy_q, busy_d;
    logic [31:0]       cfg_data_q, cfg_data_d;
    logic [4:0]        cfg_addr_q, cfg_addr_d;
    logic              cfg_valid_q, cfg_valid_d;

    logic [31:0]       job_w [NREQ][NUM_WORDS];
    logic              found_c;
    logic [SW-1:0]     sel_c;
    logic [SW:0]       sum_c;

    for (genvar r = 0; r < NREQ; r++) begin : g_req
        for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
            assign job_w[r][w] = job_data_i[(r*NUM_WORDS+w)*32 +: 32];
        end
    end

    // First requesting index at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found_c = 1'b0;
        sel_c   = '0;
        sum_c   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum_c = {1'b0, rr_ptr_q} + (SW+1)'(i);
            if (sum_c >= (SW+1)'(NREQ)) begin
                sum_c = sum_c - (SW+1)'(NREQ);
            end
            if (!found_c && req_i[sum_c[SW-1:0]]) begin
                found_c = 1'b1;
                sel_c   = sum_c[SW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        desc_d   = desc_q;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    for (int w = 0; w < NUM_WORDS; w++) begin
                        desc_d[w] = job_w[sel_c][w];
                    end
                    sel_d    = sel_c;
                    gnt_d    = NREQ'(1) << sel_c;
                    rr_ptr_d = (sel_c == SW'(NREQ-1)) ? '0 : sel_c + SW'(1);
                    k_d      = '0;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: state_d = S_WRITE;
            S_WRITE: begin
                if (cfg_valid_q && cfg_ready_i) begin
                    if (k_q == KW'(NUM_WORDS-1)) begin
                        state_d = S_START;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_START: begin
                if (cfg_valid_q && cfg_ready_i) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // eot takes priority over a timeout in the same cycle
                if (eot_event_i) begin
                    done_d  = NREQ'(1) << sel_q;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT_CYC-1)) begin
                    err_d   = NREQ'(1) << sel_q;
                    state_d = S_IDLE;
                end else if (!(&cnt_q)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        busy_d      = (state_d != S_IDLE);
        cfg_valid_d = (state_d == S_WRITE) || (state_d == S_START);
        cfg_addr_d  = '0;
        cfg_data_d  = '0;
        if (state_d == S_START) begin
            cfg_addr_d = START_ADDR;
            cfg_data_d = 32'h1;
        end else if (state_d == S_WRITE) begin
            cfg_addr_d = BASE_ADDR + 5'(k_d);
            cfg_data_d = desc_d[k_d];
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            for (int w = 0; w < NUM_WORDS; w++) begin
                desc_q[w] <= '0;
            end
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            cfg_data_q  <= '0;
            cfg_addr_q  <= '0;
            cfg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            desc_q      <= desc_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            cfg_data_q  <= cfg_data_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign cfg_data_o  = cfg_data_q;
    assign cfg_addr_o  = cfg_addr_q;
    assign cfg_valid_o = cfg_valid_q;
    assign cfg_rwn_o   = 1'b0;

endmodule

// File: tb/tb_udma_filter_sched.sv
// Directed bench for udma_filter_sched: a table of jobs (grant order, write
// sequence, backpressure, done/timeout timing) plus a reset-mid-job sequence.
module tb_udma_filter_sched;

    localparam int NREQ = 4;
    localparam int NW   = 4;
    localparam int TO   = 20;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [NREQ-1:0]        req_i;
    logic [NREQ*NW*32-1:0]  job_data;
    logic [NREQ-1:0]        gnt_o, done_o, err_o;
    logic                   busy_o;
    logic [31:0]            cfg_data_o;
    logic [4:0]             cfg_addr_o;
    logic                   cfg_valid_o, cfg_rwn_o;
    logic                   cfg_ready_i;
    logic                   eot_event_i;

    udma_filter_sched #(
        .NREQ(NREQ), .NUM_WORDS(NW), .BASE_ADDR(5'h00),
        .START_ADDR(5'h14), .TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk_i(clk), .rstn_i(rstn), .req_i(req_i), .job_data_i(job_data),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o), .cfg_valid_o(cfg_valid_o),
        .cfg_rwn_o(cfg_rwn_o), .cfg_ready_i(cfg_ready_i), .eot_event_i(eot_event_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        bit         hold;
        int         bp_word;
        bit         eot_wr;
        int         eot_dly;
        logic [3:0] gnt;
        logic [3:0] done;
        logic [3:0] err;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int r, input int k);
        return {8'hA5, 8'(r), 8'(k), 8'h3C};
    endfunction

    task automatic run_job(input vec_t v);
        int         t, gcyc, scyc, wr, stall, held, r, tend;
        bit         got;
        logic [4:0] exp_a;
        logic [31:0] exp_d;
        req_i = v.req;
        got   = 0;
        for (t = 0; t < 20 && !got; t++) begin
            tick();
            if (gnt_o != '0) got = 1;
        end
        chk("gnt_vec", gnt_o, v.gnt);
        chk("gnt_lat", t, 1);
        if (!got) return;
        gcyc = cyc;
        r = 0;
        for (int b = 0; b < NREQ; b++) if (v.gnt[b]) r = b;
        if (!v.hold) req_i = req_i & ~gnt_o;
        tick();

        wr = 0; stall = 0; held = 0; scyc = 0;
        for (t = 0; t < 40 && wr < NW + 1; t++) begin
            eot_event_i = v.eot_wr && (t == 1);
            exp_a = (wr < NW) ? 5'(wr) : 5'h14;
            exp_d = (wr < NW) ? word(r, wr) : 32'h1;
            cfg_ready_i = 1'b1;
            chk("wr_valid", cfg_valid_o, 1);
            chk("wr_addr", cfg_addr_o, exp_a);
            chk("wr_data", cfg_data_o, exp_d);
            if (v.bp_word == wr && cfg_valid_o) begin
                held++;
                if (stall < 3) begin
                    cfg_ready_i = 1'b0;
                    stall++;
                end
            end
            if (cfg_valid_o && cfg_ready_i) begin
                wr++;
                scyc = cyc;
            end
            tick();
        end
        eot_event_i = 1'b0;
        cfg_ready_i = 1'b1;
        chk("wr_count", wr, NW + 1);
        if (v.bp_word >= 0) chk("bp_hold", held, 4);
        else                chk("start_lat", scyc - gcyc, NW + 1);
        chk("wait_valid", cfg_valid_o, 0);
        chk("wait_busy", busy_o, 1);

        got = 0;
        for (t = 1; t <= TO + 5 && !got; t++) begin
            eot_event_i = (v.eot_dly == t);
            tick();
            eot_event_i = 1'b0;
            if ((done_o | err_o) != '0) got = 1;
        end
        tend = (v.eot_dly != 0) ? v.eot_dly : TO;
        chk("end_lat", cyc - scyc, tend + 1);
        chk("done_vec", done_o, v.done);
        chk("err_vec", err_o, v.err);
    endtask

    initial begin
        bit got;
        tv[0] = '{4'b0010, 0, -1, 0, 10, 4'b0010, 4'b0010, 4'b0000};
        tv[1] = '{4'b1000, 0,  2, 0,  5, 4'b1000, 4'b1000, 4'b0000};
        tv[2] = '{4'b1111, 1, -1, 0,  3, 4'b0001, 4'b0001, 4'b0000};
        tv[3] = '{4'b1111, 1, -1, 0,  3, 4'b0010, 4'b0010, 4'b0000};
        tv[4] = '{4'b1111, 1, -1, 0,  3, 4'b0100, 4'b0100, 4'b0000};
        tv[5] = '{4'b1111, 1, -1, 0,  3, 4'b1000, 4'b1000, 4'b0000};
        tv[6] = '{4'b1001, 0, -1, 0,  2, 4'b0001, 4'b0001, 4'b0000};
        tv[7] = '{4'b0100, 0, -1, 0,  0, 4'b0100, 4'b0000, 4'b0100};
        tv[8] = '{4'b0010, 0, -1, 1,  4, 4'b0010, 4'b0010, 4'b0000};
        tv[9] = '{4'b0001, 0, -1, 0, TO, 4'b0001, 4'b0001, 4'b0000};

        for (int r = 0; r < NREQ; r++)
            for (int k = 0; k < NW; k++)
                job_data[(r*NW+k)*32 +: 32] = word(r, k);
        rstn = 1'b0; req_i = '0; cfg_ready_i = 1'b1; eot_event_i = 1'b0;
        tick(); tick();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", cfg_valid_o, 0);
        chk("rst_addr", cfg_addr_o, 0);
        chk("rst_data", cfg_data_o, 0);
        chk("rst_rwn", cfg_rwn_o, 0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_job(tv[i]);
            if (tv[i].err != '0) begin
                // a stray eot in IDLE must not complete anything
                eot_event_i = 1'b1;
                tick();
                eot_event_i = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    chk("stale_done", done_o, 0);
                    chk("stale_err", err_o, 0);
                    chk("stale_busy", busy_o, 0);
                    tick();
                end
            end
        end

        // Reset mid-write with ready low; rr_ptr is 1 here, so 1010 grants bit 1.
        tick();
        req_i = 4'b1010;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if (gnt_o != '0) got = 1;
        end
        chk("rstjob_gnt", gnt_o, 4'b0010);
        cfg_ready_i = 1'b0;
        tick(); tick();
        chk("rstjob_valid", cfg_valid_o, 1);
        chk("rstjob_busy", busy_o, 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", cfg_valid_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_err", err_o, 0);
        cfg_ready_i = 1'b1;
        tick(); tick();
        rstn = 1'b1;
        // rr_ptr back at 0 picks bit 1 again (a stale pointer of 2 would pick bit 3)
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            chk("postrst_noend", done_o | err_o, 0);
            if (gnt_o != '0) got = 1;
        end
        chk("postrst_gnt", gnt_o, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udma_filter_sched.md
Name: udma_filter_sched

Overview:
- Round-robin job scheduler that shares one uDMA filter instance between NREQ requesters.
- Latches the granted requester's job descriptor, programs it into the filter over the filter's cfg bus, writes the start register, then waits for the filter's end-of-transfer event.
- Returns a per-requester done or timeout pulse, then serves the next requester.
- Sits between core-side accelerator drivers and the filter cfg port, on the peripheral clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NUM_WORDS, 4, 32-bit descriptor words per job.
- BASE_ADDR, 5'h00, cfg address of descriptor word 0; word k goes to BASE_ADDR+k.
- START_ADDR, 5'h14, cfg address of the filter start register; written with 32'h1.
- TIMEOUT_CYC, 65535, maximum cycles in WAIT_EOT before abort; must be at least 1.

Ports:
- sys_clk_i  in  1  clock.
- rstn_i  in  1  reset.
- req_i  in  NREQ  per-requester job request level; held until gnt_o.
- job_data_i  in  NREQ*NUM_WORDS*32  descriptors; requester r, word k at bits [(r*NUM_WORDS+k)*32 +: 32].
- gnt_o  out  NREQ  one-hot pulse: descriptor captured.
- done_o  out  NREQ  one-hot pulse: job finished by eot.
- err_o  out  NREQ  one-hot pulse: job aborted by timeout.
- busy_o  out  1  high in any state other than IDLE.
- cfg_data_o  out  32  cfg write data.
- cfg_addr_o  out  5  cfg address.
- cfg_valid_o  out  1  cfg request valid.
- cfg_rwn_o  out  1  always 0 (write-only master).
- cfg_ready_i  in  1  filter accepts the cfg request.
- eot_event_i  in  1  filter eot event, single-cycle pulse.

Interface decisions:
- One clock, sys_clk_i.
- Reset rstn_i is asynchronous and active-low.
- All outputs are registered.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, rr_ptr=0, word counter 0, timeout counter 0.
- Reset mid-job drops the job silently; no done_o or err_o is issued.

State machine:
- IDLE: if any req_i bit is set, select the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Same cycle: capture all NUM_WORDS of that requester's descriptor into a local buffer.
  - Next cycle: gnt_o[sel]=1 for one cycle; rr_ptr <= (sel+1) mod NREQ; go to WRITE with k=0.
- WRITE: cfg_valid_o=1, cfg_addr_o=BASE_ADDR+k, cfg_data_o=buf[k].
  - Address and data stay stable while cfg_ready_i=0.
  - On valid&ready: if k==NUM_WORDS-1 go to START, else k++ and present the next word in the following cycle (valid stays high, back-to-back).
- START: cfg_valid_o=1, cfg_addr_o=START_ADDR, cfg_data_o=32'h1.
  - On ready go to WAIT_EOT and clear the timeout counter.
- WAIT_EOT: cfg_valid_o=0; counter increments each cycle.
  - On eot_event_i: done_o[sel] pulses the next cycle; go to IDLE.
  - Otherwise, when counter==TIMEOUT_CYC-1: err_o[sel] pulses the next cycle; go to IDLE.
  - If eot_event_i and timeout coincide in the same cycle, eot wins (done_o, no err_o).
- eot_event_i outside WAIT_EOT is ignored; a stale eot cannot complete a later job.
- Requests arriving while busy_o=1 wait; fairness holds because rr_ptr advances only on grant.
- A requester dropping req_i before grant is legal and is simply not selected.
- IDLE is re-entered on the cycle after done_o/err_o; a new grant may issue 1 cycle later.

Minimum latency, cfg_ready_i tied high, req_i rising at cycle 0:
- Cycle 1: gnt_o.
- Cycles 2..NUM_WORDS+1: descriptor words.
- Cycle NUM_WORDS+2: start write.
- done_o one cycle after eot_event_i.

Arithmetic and width rules:
- BASE_ADDR+k is 5-bit and wraps modulo 32; configurations must keep it below 32 by construction.
- The timeout counter is $clog2(TIMEOUT_CYC+1) bits and saturates at its terminal value.

Test Plan:
- Single job, NREQ=4: req_i=4'b0010, ready high, eot 10 cycles after start → gnt_o=0010 at cycle 1; writes to addr 0x00..0x03 carrying buf words, then 0x14/0x1; done_o=0010 exactly 1 cycle after eot.
- Backpressure: cfg_ready_i low 3 cycles on word 2 → addr 0x02 and data held stable for 4 cycles; no word skipped or duplicated; total write count 5.
- Round-robin: req_i=4'b1111 held → grant order 0,1,2,3,0; with 4'b1001 after serving 3 → next grant is 0.
- Timeout: TIMEOUT_CYC=20, no eot → err_o[sel] pulse 20 cycles after start handshake, no done_o; stale eot arriving afterwards in IDLE produces no pulse.
- Eot coinciding with the timeout cycle → done_o only. Eot during WRITE → ignored; job still waits for a later eot.
- Reset asserted asynchronously in WRITE with ready low → cfg_valid_o and busy_o drop immediately; after release, pending req_i is re-granted from rr_ptr=0.
